// File: rtl/mult_sched_pkg.sv
// Shared widths and the requester tag that rides alongside the multiplier pipeline.
package mult_sched_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned W_DEF     = 9;
  localparam int unsigned LAT_DEF   = 3;
  localparam int unsigned IDX_W     = $clog2(N_REQ_DEF);
  localparam int unsigned P_W       = 2 * W_DEF;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or after ptr wins.
module rr_arbiter #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic             grant_any
);

  logic [IW-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IW'((32'(ptr) + k) % N_REQ);
      if (!grant_any && req_valid[cand]) begin
        grant[cand] = 1'b1;
        grant_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_sched.sv
// Shares one pipelined multiplier among N_REQ requesters; a tag pipeline steers
// each product back to the requester that issued it.
module mult_share_sched
  import mult_sched_pkg::*;
#(
  parameter  int unsigned N_REQ = N_REQ_DEF,
  parameter  int unsigned W     = W_DEF,
  parameter  int unsigned LAT   = LAT_DEF,
  localparam int unsigned CNT_W = $clog2(LAT + 3)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic [W-1:0]       mul_a,
  output logic [W-1:0]       mul_b,
  output logic               mul_vld,
  input  logic [2*W-1:0]     mul_p,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [2*W-1:0]     rsp_p,
  output logic [CNT_W-1:0]   inflight
);

  // Tag width comes from the package, so N_REQ must not exceed 2**IDX_W.
  logic [IDX_W-1:0] ptr_q, ptr_d, gidx;
  logic [N_REQ-1:0] grant;
  logic             grant_any, grant_ok;
  logic [W-1:0]     mul_a_q, mul_b_q;
  logic             mul_vld_q;
  logic [N_REQ-1:0] rsp_valid_q, rsp_onehot;
  logic [2*W-1:0]   rsp_p_q;
  logic [CNT_W-1:0] inflight_q, inflight_d;

  // tag_q[k] is k cycles behind the issue register; tag_q[LAT] lines up with mul_p.
  tag_t tag_q [LAT+1];

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .req_valid(req_valid),
    .ptr      (ptr_q),
    .grant    (grant),
    .grant_any(grant_any)
  );

  always_comb begin
    grant_ok  = grant_any & ~rst;
    req_ready = rst ? '0 : grant;
    gidx      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (grant[k]) gidx = IDX_W'(k);
    end
    ptr_d      = (gidx == IDX_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
    rsp_onehot = N_REQ'(1) << tag_q[LAT].idx;
    inflight_d = inflight_q + CNT_W'(grant_ok) - CNT_W'(|rsp_valid_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_vld_q   <= 1'b0;
      rsp_valid_q <= '0;
      rsp_p_q     <= '0;
      inflight_q  <= '0;
      for (int unsigned k = 0; k <= LAT; k++) tag_q[k] <= '0;
    end else begin
      mul_vld_q <= grant_ok;
      if (grant_ok) begin
        ptr_q   <= ptr_d;
        mul_a_q <= req_a[gidx*W +: W];
        mul_b_q <= req_b[gidx*W +: W];
      end
      tag_q[0] <= '{valid: grant_ok, idx: gidx};
      for (int unsigned k = 1; k <= LAT; k++) tag_q[k] <= tag_q[k-1];
      rsp_valid_q <= tag_q[LAT].valid ? rsp_onehot : '0;
      if (tag_q[LAT].valid) rsp_p_q <= mul_p;
      inflight_q <= inflight_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_vld   = mul_vld_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_p     = rsp_p_q;
  assign inflight  = inflight_q;

endmodule
